// File: rtl/exec_pkg.sv
// Shared types for the execute stage: micro-op codes, ARM condition codes,
// NZCV flags, control state and branch-condition evaluation.
package exec_pkg;

  typedef enum logic [4:0] {
    UOP_NOP     = 5'd0,
    UOP_MOV     = 5'd1,
    UOP_ADD     = 5'd2,
    UOP_SUB     = 5'd3,
    UOP_AND     = 5'd4,
    UOP_ORR     = 5'd5,
    UOP_EOR     = 5'd6,
    UOP_CMP     = 5'd7,
    UOP_MUL     = 5'd8,
    UOP_GPIO_WR = 5'd9,
    UOP_GPIO_RD = 5'd10,
    UOP_B       = 5'd11
  } uop_t;

  typedef enum logic [3:0] {
    EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL, NV
  } cond_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  function automatic logic cond_pass(cond_t cond, flags_t f);
    case (cond)
      EQ:      cond_pass = f.z;
      NE:      cond_pass = !f.z;
      CS:      cond_pass = f.c;
      CC:      cond_pass = !f.c;
      MI:      cond_pass = f.n;
      PL:      cond_pass = !f.n;
      VS:      cond_pass = f.v;
      VC:      cond_pass = !f.v;
      HI:      cond_pass = f.c && !f.z;
      LS:      cond_pass = !f.c || f.z;
      GE:      cond_pass = (f.n == f.v);
      LT:      cond_pass = (f.n != f.v);
      GT:      cond_pass = !f.z && (f.n == f.v);
      LE:      cond_pass = f.z || (f.n != f.v);
      AL:      cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/exec_mul.sv
// Radix-2 shift-add multiplier: one multiplier bit per cycle for WIDTH cycles.
// done is asserted combinationally on the final iteration together with the low product.
module exec_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH);

  logic             running;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;

  assign product = mplier[0] ? acc + mcand : acc;
  assign done    = running && (count == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      running <= 1'b0;
      count   <= '0;
    end else if (start) begin
      running <= 1'b1;
      count   <= '0;
    end else if (running) begin
      count <= count + 1'b1;
      if (done) running <= 1'b0;
    end
  end

  // Only the low WIDTH bits of the product are kept, so the multiplicand
  // may shift its upper bits out.
  always_ff @(posedge clk) begin
    if (start) begin
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
    end else if (running) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/execute_unit.sv
// Execute stage: register file, NZCV flags, ALU, conditional branch with
// one-op squash, iterative multiplier and synchronised GPIO.
module execute_unit
  import exec_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int NUM_REGS   = 16,
  parameter int GPIO_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  uop_t                        uop,
  input  logic [$clog2(NUM_REGS)-1:0] sel_in,
  input  logic [$clog2(NUM_REGS)-1:0] sel_p0,
  input  logic [$clog2(NUM_REGS)-1:0] sel_p1,
  input  logic [WIDTH-1:0]            num,
  input  logic                        num_to_rhs,
  input  cond_t                       branch_cond,
  output logic                        branch_valid,
  output logic [WIDTH-1:0]            branch_delta,
  output logic [3:0]                  flags_out,
  output logic                        busy,
  input  logic [GPIO_WIDTH-1:0]       gpio_in,
  output logic [GPIO_WIDTH-1:0]       gpio_out
);

  localparam int SEL_W = $clog2(NUM_REGS);

  logic [WIDTH-1:0]      regs [NUM_REGS];
  flags_t                flags;
  state_t                state;
  logic                  squash;
  logic [GPIO_WIDTH-1:0] gpio_sync_p0;
  logic [GPIO_WIDTH-1:0] gpio_sync_p1;
  logic [SEL_W-1:0]      mul_rd;

  logic [WIDTH-1:0]        lhs, rhs, logic_res, mul_product;
  logic signed [WIDTH-1:0] lhs_s, rhs_s, add_s, sub_s;
  logic [WIDTH:0]          add_sum, sub_diff;
  logic                    add_v, sub_v, exec_op, mul_start, mul_done;

  assign in_ready  = (state == ST_IDLE);
  assign busy      = (state == ST_MUL);
  assign flags_out = flags;

  assign lhs       = regs[sel_p1];
  assign rhs       = num_to_rhs ? num : regs[sel_p0];
  assign exec_op   = in_valid && in_ready && !squash;
  assign mul_start = exec_op && (uop == UOP_MUL);

  assign add_sum  = {1'b0, lhs} + {1'b0, rhs};
  assign sub_diff = {1'b0, lhs} - {1'b0, rhs};
  assign lhs_s    = $signed(lhs);
  assign rhs_s    = $signed(rhs);
  assign add_s    = $signed(add_sum[WIDTH-1:0]);
  assign sub_s    = $signed(sub_diff[WIDTH-1:0]);
  assign add_v    = ((lhs_s < 0) == (rhs_s < 0)) && ((add_s < 0) != (lhs_s < 0));
  assign sub_v    = ((lhs_s < 0) != (rhs_s < 0)) && ((sub_s < 0) != (lhs_s < 0));

  always_comb begin
    logic_res = lhs & rhs;
    case (uop)
      UOP_ORR: logic_res = lhs | rhs;
      UOP_EOR: logic_res = lhs ^ rhs;
      default: ;
    endcase
  end

  exec_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (lhs),
    .b       (rhs),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      flags        <= '0;
      gpio_out     <= '0;
      branch_valid <= 1'b0;
      branch_delta <= '0;
      state        <= ST_IDLE;
      squash       <= 1'b0;
      gpio_sync_p0 <= '0;
      gpio_sync_p1 <= '0;
    end else begin
      // synchroniser stage p0 -> p1
      gpio_sync_p0 <= gpio_in;
      gpio_sync_p1 <= gpio_sync_p0;
      branch_valid <= 1'b0;
      squash       <= 1'b0;
      if (state == ST_MUL) begin
        if (mul_done) begin
          regs[mul_rd] <= mul_product;
          flags.n      <= mul_product[WIDTH-1];
          flags.z      <= ~|mul_product;
          state        <= ST_IDLE;
        end
      end else if (exec_op) begin
        case (uop)
          UOP_MOV: regs[sel_in] <= rhs;
          UOP_ADD: begin
            regs[sel_in] <= add_sum[WIDTH-1:0];
            flags <= {add_sum[WIDTH-1], ~|add_sum[WIDTH-1:0], add_sum[WIDTH], add_v};
          end
          UOP_SUB: begin
            regs[sel_in] <= sub_diff[WIDTH-1:0];
            flags <= {sub_diff[WIDTH-1], ~|sub_diff[WIDTH-1:0], ~sub_diff[WIDTH], sub_v};
          end
          UOP_CMP:
            flags <= {sub_diff[WIDTH-1], ~|sub_diff[WIDTH-1:0], ~sub_diff[WIDTH], sub_v};
          UOP_AND, UOP_ORR, UOP_EOR: begin
            regs[sel_in] <= logic_res;
            flags.n      <= logic_res[WIDTH-1];
            flags.z      <= ~|logic_res;
          end
          UOP_MUL: begin
            state  <= ST_MUL;
            mul_rd <= sel_in;
          end
          UOP_GPIO_WR: gpio_out <= rhs[GPIO_WIDTH-1:0];
          UOP_GPIO_RD: regs[sel_in] <= WIDTH'(gpio_sync_p1);
          UOP_B: begin
            if (cond_pass(branch_cond, flags)) begin
              branch_valid <= 1'b1;
              branch_delta <= num;
              squash       <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_execute_unit.sv
// Bench for execute_unit: cycle-level reference model plus directed vectors,
// with a second small-parameter instance for the narrow-width corner cases.
module tb_execute_unit;
  import exec_pkg::*;

  logic clk;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   last_wait;
  logic chk_en = 1'b0;

  // 32-bit instance
  logic        in_valid, in_ready, num_to_rhs, branch_valid, busy;
  uop_t        uop;
  cond_t       branch_cond;
  logic [3:0]  sel_in, sel_p0, sel_p1, flags_out;
  logic [31:0] num, branch_delta, gpio_in, gpio_out;

  // 8-bit instance
  logic        in_valid_8, in_ready_8, num_to_rhs_8, branch_valid_8, busy_8;
  uop_t        uop_8;
  cond_t       branch_cond_8;
  logic [1:0]  sel_in_8, sel_p0_8, sel_p1_8;
  logic [7:0]  num_8, branch_delta_8;
  logic [3:0]  flags_8, gpio_in_8, gpio_out_8;

  execute_unit dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .uop(uop),
    .sel_in(sel_in), .sel_p0(sel_p0), .sel_p1(sel_p1), .num(num), .num_to_rhs(num_to_rhs),
    .branch_cond(branch_cond), .branch_valid(branch_valid), .branch_delta(branch_delta),
    .flags_out(flags_out), .busy(busy), .gpio_in(gpio_in), .gpio_out(gpio_out)
  );

  execute_unit #(.WIDTH(8), .NUM_REGS(4), .GPIO_WIDTH(4)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid_8), .in_ready(in_ready_8), .uop(uop_8),
    .sel_in(sel_in_8), .sel_p0(sel_p0_8), .sel_p1(sel_p1_8), .num(num_8),
    .num_to_rhs(num_to_rhs_8), .branch_cond(branch_cond_8), .branch_valid(branch_valid_8),
    .branch_delta(branch_delta_8), .flags_out(flags_8), .busy(busy_8),
    .gpio_in(gpio_in_8), .gpio_out(gpio_out_8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model of the 32-bit instance, written from the architectural rules
  logic [31:0] m_regs [16];
  logic [3:0]  m_flags = '0;
  logic [31:0] m_gpio = '0, m_bd = '0, m_prod = '0, m_h0 = '0, m_h1 = '0;
  logic        m_bv = 1'b0, m_squash = 1'b0;
  logic [3:0]  m_rd = '0;
  int          m_left = 0;

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic base;
    if (c == 4'd15) return 1'b0;
    case (c[3:1])
      3'd0:    base = f[2];
      3'd1:    base = f[1];
      3'd2:    base = f[3];
      3'd3:    base = f[0];
      3'd4:    base = f[1] && !f[2];
      3'd5:    base = (f[3] == f[0]);
      3'd6:    base = !f[2] && (f[3] == f[0]);
      default: base = 1'b1;
    endcase
    return base ^ (c[0] && c != 4'd14);
  endfunction

  always @(posedge clk) begin : model
    logic [31:0]     lhs, rhs, res;
    longint unsigned u;
    longint          s;
    if (reset) begin
      for (int i = 0; i < 16; i++) m_regs[i] <= '0;
      m_flags <= '0; m_gpio <= '0; m_bv <= 1'b0; m_bd <= '0;
      m_squash <= 1'b0; m_left <= 0; m_h0 <= '0; m_h1 <= '0;
    end else begin
      m_h0 <= gpio_in;
      m_h1 <= m_h0;
      m_bv <= 1'b0;
      m_squash <= 1'b0;
      lhs = m_regs[sel_p1];
      rhs = num_to_rhs ? num : m_regs[sel_p0];
      if (m_left != 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_regs[m_rd] <= m_prod;
          m_flags <= {m_prod[31], m_prod == 0, m_flags[1:0]};
        end
      end else if (in_valid && !m_squash) begin
        case (uop)
          UOP_MOV: m_regs[sel_in] <= rhs;
          UOP_ADD, UOP_SUB, UOP_CMP: begin
            if (uop == UOP_ADD) begin
              u = longint'(lhs) + longint'(rhs);
              s = longint'($signed(lhs)) + longint'($signed(rhs));
            end else begin
              u = longint'(lhs) - longint'(rhs);
              s = longint'($signed(lhs)) - longint'($signed(rhs));
            end
            res = u[31:0];
            if (uop != UOP_CMP) m_regs[sel_in] <= res;
            m_flags <= {res[31], res == 0,
                        (uop == UOP_ADD) ? u[32] : (lhs >= rhs),
                        (s > 64'sd2147483647) || (s < -64'sd2147483648)};
          end
          UOP_AND, UOP_ORR, UOP_EOR: begin
            res = (uop == UOP_AND) ? (lhs & rhs) : (uop == UOP_ORR) ? (lhs | rhs) : (lhs ^ rhs);
            m_regs[sel_in] <= res;
            m_flags <= {res[31], res == 0, m_flags[1:0]};
          end
          UOP_MUL: begin
            u = longint'(lhs) * longint'(rhs);
            m_prod <= u[31:0];
            m_rd   <= sel_in;
            m_left <= 32;
          end
          UOP_GPIO_WR: m_gpio <= rhs;
          UOP_GPIO_RD: m_regs[sel_in] <= m_h1;
          UOP_B: if (cond_ok(branch_cond, m_flags)) begin
            m_bv <= 1'b1; m_bd <= num; m_squash <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", in_ready, m_left == 0);
      check("busy", busy, m_left != 0);
      check("flags", flags_out, m_flags);
      check("gpio_out", gpio_out, m_gpio);
      check("branch_valid", branch_valid, m_bv);
      check("branch_delta", branch_delta, m_bd);
    end
  end

  task automatic issue(input uop_t op, input int rd, input int ra, input int rb,
                       input logic [31:0] n, input logic imm, input cond_t c);
    uop = op; sel_in = 4'(rd); sel_p1 = 4'(ra); sel_p0 = 4'(rb);
    num = n; num_to_rhs = imm; branch_cond = c; in_valid = 1'b1;
    last_wait = 0;
    while (!in_ready && last_wait < 100) begin
      @(posedge clk); #1; last_wait++;
    end
    if (!in_ready) check("handshake_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; uop = UOP_NOP;
  endtask

  task automatic opi(input uop_t op, input int rd, input int ra, input logic [31:0] n);
    issue(op, rd, ra, 0, n, 1'b1, AL);
  endtask

  task automatic opr(input uop_t op, input int rd, input int ra, input int rb);
    issue(op, rd, ra, rb, 32'd0, 1'b0, AL);
  endtask

  task automatic br(input cond_t c, input logic [31:0] d);
    issue(UOP_B, 0, 0, 0, d, 1'b1, c);
  endtask

  task automatic expect_reg(input string name, input int r, input logic [31:0] exp);
    opr(UOP_GPIO_WR, 0, 0, r);
    check(name, gpio_out, exp);
  endtask

  task automatic issue8(input uop_t op, input int rd, input int ra, input int rb,
                        input logic [7:0] n, input logic imm);
    uop_8 = op; sel_in_8 = 2'(rd); sel_p1_8 = 2'(ra); sel_p0_8 = 2'(rb);
    num_8 = n; num_to_rhs_8 = imm; branch_cond_8 = AL; in_valid_8 = 1'b1;
    last_wait = 0;
    while (!in_ready_8 && last_wait < 100) begin
      @(posedge clk); #1; last_wait++;
    end
    if (!in_ready_8) check("handshake_timeout_8", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid_8 = 1'b0; uop_8 = UOP_NOP;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; uop = UOP_NOP; sel_in = '0; sel_p0 = '0; sel_p1 = '0;
    num = '0; num_to_rhs = 1'b0; branch_cond = AL; gpio_in = '0;
    in_valid_8 = 1'b0; uop_8 = UOP_NOP; sel_in_8 = '0; sel_p0_8 = '0; sel_p1_8 = '0;
    num_8 = '0; num_to_rhs_8 = 1'b0; branch_cond_8 = AL; gpio_in_8 = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_flags", flags_out, 0);
    check("rst_gpio_out", gpio_out, 0);
    check("rst_branch_valid", branch_valid, 0);
    check("rst_branch_delta", branch_delta, 0);
    reset = 1'b0;

    // reset aborts an in-flight MUL
    opi(UOP_MOV, 1, 0, 32'd7);
    opi(UOP_MOV, 2, 0, 32'd6);
    opr(UOP_MUL, 3, 1, 2);
    check("mul_started_busy", busy, 1);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("post_rst_flags", flags_out, 0);
    check("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    check("post_rst_in_ready_next", in_ready, 1);
    expect_reg("rst_mul_rd", 3, 32'd0);

    // add overflow, sub to zero
    opi(UOP_MOV, 1, 0, 32'h7FFF_FFFF);
    opi(UOP_ADD, 2, 1, 32'd1);
    check("add_ovf_flags", flags_out, 4'b1001);
    expect_reg("add_ovf_r2", 2, 32'h8000_0000);
    opr(UOP_SUB, 3, 2, 2);
    check("sub_zero_flags", flags_out, 4'b0110);
    expect_reg("sub_zero_r3", 3, 32'd0);

    // taken branch squashes the next op; not-taken branch is a NOP
    opi(UOP_MOV, 1, 0, 32'd5);
    opi(UOP_CMP, 0, 1, 32'd5);
    check("cmp_flags", flags_out, 4'b0110);
    br(EQ, 32'hFFFF_FFFD);
    check("beq_valid", branch_valid, 1);
    check("beq_delta", branch_delta, 32'hFFFF_FFFD);
    opi(UOP_MOV, 4, 0, 32'd9);
    check("beq_pulse_end", branch_valid, 0);
    check("beq_delta_hold", branch_delta, 32'hFFFF_FFFD);
    expect_reg("squashed_r4", 4, 32'd0);
    br(NE, 32'd7);
    check("bne_valid", branch_valid, 0);
    opi(UOP_MOV, 4, 0, 32'd9);
    expect_reg("after_bne_r4", 4, 32'd9);
    check("bne_delta_hold", branch_delta, 32'hFFFF_FFFD);

    // multiply with C,V preset, an op offered during busy
    opi(UOP_MOV, 1, 0, 32'h0000_FFFF);
    opi(UOP_MOV, 2, 0, 32'h0001_0001);
    opi(UOP_MOV, 7, 0, 32'h8000_0000);
    opr(UOP_ADD, 8, 7, 7);
    check("cv_preset_flags", flags_out, 4'b0111);
    opr(UOP_MUL, 5, 1, 2);
    opi(UOP_GPIO_WR, 0, 0, 32'h55);
    check("mul_stall_cycles", last_wait, 32);
    check("mul_flags", flags_out, 4'b1011);
    check("stalled_op_gpio", gpio_out, 32'h55);
    expect_reg("mul_r5", 5, 32'hFFFF_FFFF);

    // logic ops and a taken AL branch squashing a MUL
    opi(UOP_AND, 12, 1, 32'h000F_0000);
    check("and_zero_flags", flags_out, 4'b0111);
    opi(UOP_EOR, 13, 5, 32'h0000_FFFF);
    expect_reg("eor_r13", 13, 32'hFFFF_0000);
    br(AL, 32'd5);
    check("bal_delta", branch_delta, 32'd5);
    opr(UOP_MUL, 5, 1, 1);
    check("squashed_mul_busy", busy, 0);
    expect_reg("squashed_mul_r5", 5, 32'hFFFF_FFFF);
    br(NV, 32'd9);
    check("bnv_valid", branch_valid, 0);

    // GPIO output and synchroniser latency
    opi(UOP_GPIO_WR, 0, 0, 32'hA5);
    check("gpio_wr", gpio_out, 32'hA5);
    gpio_in = 32'h3C;
    opi(UOP_GPIO_RD, 6, 0, 32'd0);
    expect_reg("gpio_rd_early", 6, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    opi(UOP_GPIO_RD, 6, 0, 32'd0);
    expect_reg("gpio_rd_late", 6, 32'h3C);
    gpio_in = 32'h81;
    opi(UOP_GPIO_RD, 8, 0, 32'd0);
    opi(UOP_GPIO_RD, 9, 0, 32'd0);
    opi(UOP_GPIO_RD, 10, 0, 32'd0);
    expect_reg("gpio_rd_e1", 8, 32'h3C);
    expect_reg("gpio_rd_e2", 9, 32'h3C);
    expect_reg("gpio_rd_e3", 10, 32'h81);

    // narrow instance: WIDTH=8, NUM_REGS=4, GPIO_WIDTH=4
    issue8(UOP_MOV, 1, 0, 0, 8'hFF, 1'b1);
    issue8(UOP_ADD, 2, 1, 0, 8'h01, 1'b1);
    check("w8_add_flags", flags_8, 4'b0110);
    issue8(UOP_GPIO_WR, 0, 0, 0, 8'hFF, 1'b1);
    check("w8_gpio_wr", gpio_out_8, 4'hF);
    issue8(UOP_MUL, 3, 1, 1, 8'h00, 1'b0);
    check("w8_busy", busy_8, 1);
    issue8(UOP_NOP, 0, 0, 0, 8'h00, 1'b1);
    check("w8_mul_stall_cycles", last_wait, 8);
    check("w8_mul_flags", flags_8, 4'b0010);
    issue8(UOP_GPIO_WR, 0, 0, 3, 8'h00, 1'b0);
    check("w8_mul_r3", gpio_out_8, 4'h1);
    check("w8_branch_valid", branch_valid_8, 0);
    check("w8_branch_delta", branch_delta_8, 0);

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
